// File: rtl/alu9_pkg.sv
// Shared constants and types for the 9-bit sequenced arithmetic unit.
package alu9_pkg;

  localparam int unsigned WIDTH  = 9;
  localparam int unsigned AW     = WIDTH + 1;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned N_ADD  = 1;
  localparam int unsigned N_MUL  = 9;
  localparam int unsigned N_SQRT = 5;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_SQRT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Number of EXEC cycles an opcode occupies.
  function automatic logic [CNT_W-1:0] n_steps(input logic [1:0] op);
    case (op)
      OP_MUL:  n_steps = CNT_W'(N_MUL);
      OP_SQRT: n_steps = CNT_W'(N_SQRT);
      default: n_steps = CNT_W'(N_ADD);
    endcase
  endfunction

endpackage

// File: rtl/alu9_addsub.sv
// Shared 10-bit adder/subtractor; co_c is carry-out on add, borrow on subtract.
module alu9_addsub
  import alu9_pkg::*;
(
  input  logic [AW-1:0] x,
  input  logic [AW-1:0] y,
  input  logic          sub,
  output logic [AW-1:0] sum_c,
  output logic          co_c
);

  logic [AW:0] full;

  assign full  = {1'b0, x} + {1'b0, y ^ {AW{sub}}} + (AW+1)'(sub);
  assign sum_c = full[AW-1:0];
  assign co_c  = full[AW] ^ sub;

endmodule

// File: rtl/alu9_sequencer.sv
// Multi-cycle 9-bit ADD/SUB/MUL/SQRT unit sequencing one shared adder/subtractor
// behind valid/ready handshakes.
module alu9_sequencer
  import alu9_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             carry
);

  state_t             state, state_d;
  logic [1:0]         op_q, op_d;
  logic [AW-1:0]      opa, opa_d;     // operand A; shifted radicand for SQRT
  logic [WIDTH-1:0]   h, h_d;         // MUL high accumulator / SQRT remainder
  logic [WIDTH-1:0]   m, m_d;         // MUL multiplier->low product / SQRT root
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [WIDTH-1:0]   lo_d, hi_d;
  logic               carry_d, valid_d;

  logic [AW-1:0]      as_x, as_y, as_sum;
  logic               as_sub, as_co;

  alu9_addsub u_addsub (
    .x     (as_x),
    .y     (as_y),
    .sub   (as_sub),
    .sum_c (as_sum),
    .co_c  (as_co)
  );

  assign in_ready = (state == ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_q      <= OP_ADD;
      opa       <= '0;
      h         <= '0;
      m         <= '0;
      cnt       <= '0;
      res_lo    <= '0;
      res_hi    <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      op_q      <= op_d;
      opa       <= opa_d;
      h         <= h_d;
      m         <= m_d;
      cnt       <= cnt_d;
      res_lo    <= lo_d;
      res_hi    <= hi_d;
      carry     <= carry_d;
      out_valid <= valid_d;
    end
  end

  always_comb begin
    state_d = state;
    op_d    = op_q;
    opa_d   = opa;
    h_d     = h;
    m_d     = m;
    cnt_d   = cnt;
    lo_d    = res_lo;
    hi_d    = res_hi;
    carry_d = carry;
    valid_d = out_valid;
    as_x    = '0;
    as_y    = '0;
    as_sub  = 1'b0;

    // Shared datapath operands, selected by the latched opcode.
    unique case (op_q)
      OP_ADD: begin
        as_x = opa;
        as_y = {1'b0, m};
      end
      OP_SUB: begin
        as_x   = opa;
        as_y   = {1'b0, m};
        as_sub = 1'b1;
      end
      OP_MUL: begin
        as_x = {1'b0, h};
        as_y = m[0] ? opa : '0;
      end
      default: begin
        as_x   = {h[WIDTH-2:0], opa[AW-1:AW-2]};
        as_y   = {m[WIDTH-2:0], 2'b01};
        as_sub = 1'b1;
      end
    endcase

    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_EXEC;
          op_d    = op;
          opa_d   = {1'b0, a};
          h_d     = '0;
          m_d     = (op == OP_SQRT) ? '0 : b;
          cnt_d   = '0;
        end
      end
      ST_EXEC: begin
        cnt_d = cnt + CNT_W'(1);
        if (op_q == OP_MUL) begin
          h_d = as_sum[AW-1:1];
          m_d = {as_sum[0], m[WIDTH-1:1]};
        end else if (op_q == OP_SQRT) begin
          // Restoring step: keep the trial difference only when it did not borrow.
          opa_d = {opa[AW-3:0], 2'b00};
          h_d   = as_co ? as_x[WIDTH-1:0] : as_sum[WIDTH-1:0];
          m_d   = {m[WIDTH-2:0], ~as_co};
        end
        if (cnt == n_steps(op_q) - CNT_W'(1)) begin
          state_d = ST_DONE;
          valid_d = 1'b1;
          if (op_q == OP_ADD || op_q == OP_SUB) begin
            lo_d    = as_sum[WIDTH-1:0];
            hi_d    = '0;
            carry_d = (op_q == OP_ADD) ? as_sum[AW-1] : as_co;
          end else begin
            lo_d    = m_d;
            hi_d    = h_d;
            carry_d = 1'b0;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu9_sequencer.sv
// Randomized self-checking bench for alu9_sequencer against an arithmetic reference model.
module tb_alu9_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, carry;
  logic [1:0] op;
  logic [8:0] a, b, res_lo, res_hi;

  int n_checks = 0;
  int n_errors = 0;

  alu9_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res_lo    (res_lo),
    .res_hi    (res_hi),
    .carry     (carry)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference result as {carry, hi, lo} in plain integer arithmetic.
  function automatic void model(input int o, input int x, input int y,
                                output int lo, output int hi, output int cy);
    int r;
    lo = 0; hi = 0; cy = 0;
    case (o)
      0: begin lo = (x + y) % 512; cy = (x + y >= 512) ? 1 : 0; end
      1: begin lo = (x - y + 512) % 512; cy = (x < y) ? 1 : 0; end
      2: begin lo = (x * y) % 512; hi = (x * y) / 512; end
      default: begin
        r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        lo = r; hi = x - r * r;
      end
    endcase
  endfunction

  function automatic int latency(input int o);
    return (o == 2) ? 9 : (o == 3) ? 5 : 1;
  endfunction

  // Accept one command, wait for the result, check it, optionally stall, then consume.
  task automatic run_op(input int o, input int x, input int y, input int hold, input string tag);
    int lo, hi, cy, t, lat;
    model(o, x, y, lo, hi, cy);
    @(negedge clk);
    in_valid = 1'b1; op = 2'(o); a = 9'(x); b = 9'(y);
    t = 0;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    check_eq({tag, "_ready"}, 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0; op = 2'($urandom); a = 9'($urandom); b = 9'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    check_eq({tag, "_lat"}, lat, latency(o));
    check_eq({tag, "_lo"}, 32'(res_lo), lo);
    check_eq({tag, "_hi"}, 32'(res_hi), hi);
    check_eq({tag, "_cy"}, 32'(carry), cy);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq({tag, "_hold_v"}, 32'(out_valid), 1);
      check_eq({tag, "_hold_rdy"}, 32'(in_ready), 0);
      check_eq({tag, "_hold_lo"}, 32'(res_lo), lo);
      check_eq({tag, "_hold_hi"}, 32'(res_hi), hi);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq({tag, "_idle_v"}, 32'(out_valid), 0);
    check_eq({tag, "_idle_rdy"}, 32'(in_ready), 1);
  endtask

  initial begin
    int o;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 2'd0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_lo", 32'(res_lo), 0);
    check_eq("rst_hi", 32'(res_hi), 0);
    check_eq("rst_cy", 32'(carry), 0);
    check_eq("rst_v", 32'(out_valid), 0);
    check_eq("rst_rdy", 32'(in_ready), 1);
    @(negedge clk); rst = 1'b0;

    run_op(0, 300, 300, 0, "add300");
    run_op(1, 5, 7, 0, "sub5_7");
    run_op(1, 7, 5, 0, "sub7_5");
    run_op(2, 511, 511, 0, "mul_max");
    run_op(2, 0, 511, 0, "mul_zero");
    run_op(3, 25, 0, 0, "sqrt25");
    run_op(3, 511, 0, 0, "sqrt511");
    run_op(3, 0, 0, 0, "sqrt0");

    // Backpressure on a MUL with the next command already waiting.
    run_op(2, 123, 456, 0, "bp_pre");
    @(negedge clk); in_valid = 1'b1; op = 2'd2; a = 9'd300; b = 9'd200;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check_eq("bp_v", 32'(out_valid), 1);
    in_valid = 1'b1; op = 2'd0; a = 9'd1; b = 9'd1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("bp_rdy", 32'(in_ready), 0);
      check_eq("bp_lo", 32'(res_lo), (300 * 200) % 512);
      check_eq("bp_hi", 32'(res_hi), (300 * 200) / 512);
      check_eq("bp_v_hold", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("bp_release_rdy", 32'(in_ready), 1);
    check_eq("bp_release_v", 32'(out_valid), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("bp_accept_rdy", 32'(in_ready), 0);
    @(posedge clk); #1;
    check_eq("bp_add_v", 32'(out_valid), 1);
    check_eq("bp_add_lo", 32'(res_lo), 2);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in the 4th EXEC cycle of a MUL after a non-zero result is on the outputs.
    run_op(0, 400, 300, 0, "pre_rst");
    @(negedge clk); in_valid = 1'b1; op = 2'd2; a = 9'd77; b = 9'd99;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_lo", 32'(res_lo), 0);
    check_eq("mid_rst_hi", 32'(res_hi), 0);
    check_eq("mid_rst_cy", 32'(carry), 0);
    check_eq("mid_rst_v", 32'(out_valid), 0);
    check_eq("mid_rst_rdy", 32'(in_ready), 1);
    @(negedge clk); rst = 1'b0;
    run_op(0, 1, 2, 0, "post_rst_add");

    for (int i = 0; i < 200; i++) begin
      o = int'($urandom_range(3, 0));
      run_op(o, int'($urandom_range(511, 0)), int'($urandom_range(511, 0)),
             int'($urandom_range(2, 0)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
